// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed multiply (radix-2 shift-add, or radix-4 Booth when MULTDIV_BOOTH4_EN is defined)
// and restoring divide, with overflow/divide-by-zero exception flag.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_BOOTH4_EN
  localparam int PW = 2 * WIDTH + 3;
  localparam int MUL_N = WIDTH / 2;
`else
  localparam int PW = 2 * WIDTH;
  localparam int MUL_N = WIDTH;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [PW-1:0]    p_q;
  logic             neg_q, dz_q, ovf_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q, rdy_q, busy_q;
  logic [WIDTH-1:0] sh, q;
  logic [WIDTH:0]   dtrial;
  logic [2*WIDTH-1:0] div_d, prod;
  logic [PW-1:0]    mul_d;
  logic             mexc;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
`ifdef MULTDIV_BOOTH4_EN
  logic [WIDTH+1:0] ae, badd, accn;
  logic [2:0]       sel;
  always_comb begin
    sel   = p_q[2:0];
    ae    = {{2{a_q[WIDTH-1]}}, a_q};
    badd  = (sel == 3'b001 || sel == 3'b010) ? ae :
            (sel == 3'b011) ? (ae << 1) :
            (sel == 3'b100) ? -(ae << 1) :
            (sel == 3'b101 || sel == 3'b110) ? -ae : '0;
    accn  = p_q[PW-1:WIDTH+1] + badd;
    mul_d = {{2{accn[WIDTH+1]}}, accn, p_q[WIDTH:2]};
    prod  = p_q[2*WIDTH:1];
  end
`else
  logic [WIDTH:0] sum;
  always_comb begin
    sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? a_q : {WIDTH{1'b0}}};
    mul_d = {sum, p_q[WIDTH-1:1]};
    prod  = neg_q ? -p_q : p_q;
  end
`endif
  // Remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so the shifted partial fits WIDTH bits.
  always_comb begin
    sh     = {p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]};
    dtrial = {1'b0, sh} - {1'b0, a_q};
    div_d  = dtrial[WIDTH] ? {sh, p_q[WIDTH-2:0], 1'b0} : {dtrial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    q      = p_q[WIDTH-1:0];
    mexc   = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      state_q <= ctrl_MULT ? MUL : DIV;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      rdy_q   <= 1'b0;
      exc_q   <= 1'b0;
      neg_q   <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
      dz_q    <= operand_B == '0;
      ovf_q   <= operand_A == {1'b1, {(WIDTH-1){1'b0}}} && operand_B == '1;
`ifdef MULTDIV_BOOTH4_EN
      a_q     <= ctrl_MULT ? operand_A : mag(operand_B);
      p_q     <= ctrl_MULT ? PW'({operand_B, 1'b0}) : PW'(mag(operand_A));
`else
      a_q     <= ctrl_MULT ? mag(operand_A) : mag(operand_B);
      p_q     <= ctrl_MULT ? PW'(mag(operand_B)) : PW'(mag(operand_A));
`endif
    end else if (state_q == MUL) begin
      if (cnt_q == CW'(MUL_N)) begin
        result_q <= prod[WIDTH-1:0];
        exc_q    <= mexc;
        rdy_q    <= 1'b1;
        state_q  <= DONE;
      end else begin
        p_q   <= mul_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (state_q == DIV) begin
      if (cnt_q == CW'(WIDTH)) begin
        result_q <= dz_q ? '0 : neg_q ? -q : q;
        exc_q    <= dz_q | ovf_q;
        rdy_q    <= 1'b1;
        state_q  <= DONE;
      end else begin
        p_q   <= PW'(div_d);
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      rdy_q   <= 1'b0;
      exc_q   <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= IDLE;
    end
  end
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule
